// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and nibble width for the sequential CLA adder
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/cla_seq_adder_cla.sv
// CLA_adder: 4-bit carry-lookahead adder slice
module CLA_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: wide adder that reuses one 4-bit CLA slice per clock, LS nibble first
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW = $clog2(NIB);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry, a_msb, b_msb, cout_q, ovf_q, last;
  logic [NIBBLE_W-1:0] s_nib;
  logic s_cout;
  CLA_adder u_cla (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (s_nib),
    .cout (s_cout)
  );
  assign last = cnt == CW'(NIB - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sh   <= a_sh >> NIBBLE_W;
        b_sh   <= b_sh >> NIBBLE_W;
        sum_sh <= {s_nib, sum_sh[WIDTH-1:NIBBLE_W]};
        carry  <= s_cout;
        cnt    <= cnt + 1'b1;
        // latch flags on the final step so they stay put until the next result
        if (last) begin
          cout_q <= s_cout;
          ovf_q  <= (a_msb == b_msb) & (s_nib[NIBBLE_W-1] != a_msb);
        end
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sum       = sum_sh;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed vector table plus hold, reset and back-to-back sequences
module tb_cla_seq_adder;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum;
  int n_cmp = 0, n_bad = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [15:0] s;
    logic co, ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int lat;
    out_ready = 1;
    a = v.a; b = v.b; cin = v.cin; in_valid = 1;
    check("in_ready_before_accept", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 4);
    check("sum", 32'(sum), 32'(v.s));
    check("cout", 32'(cout), 32'(v.co));
    check("ovf", 32'(ovf), 32'(v.ov));
    @(posedge clk); #1;
    check("out_valid_one_cycle", 32'(out_valid), 0);
    check("in_ready_after", 32'(in_ready), 1);
  endtask

  vec_t vt[8];
  vec_t pr[3];
  int t_acc[3];

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[4] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vt[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_txn(vt[i]);

    // result held while consumer stalls; new operands must be ignored
    out_ready = 0;
    a = 16'h1111; b = 16'h2222; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("hold_valid", 32'(out_valid), 1);
    a = 16'h0001; b = 16'h0001; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_sum", 32'(sum), 32'h3333);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_busy", 32'(busy), 1);
      check("hold_out_valid", 32'(out_valid), 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
    check("release_busy", 32'(busy), 0);

    // asynchronous reset mid-RUN discards the transaction
    a = 16'h1234; b = 16'h4321; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 1);
    rst_n = 0; #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_sum", 32'(sum), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst_n = 1;
    do_txn(vt[4]);

    // back-to-back with in_valid and out_ready held high
    pr[0] = '{16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0};
    pr[1] = '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1};
    pr[2] = '{16'hFFF0, 16'h0010, 1'b1, 16'h0001, 1'b1, 1'b0};
    begin
      int ii = 0, io = 0;
      logic acc;
      out_ready = 1;
      a = pr[0].a; b = pr[0].b; cin = pr[0].cin; in_valid = 1;
      for (int cyc = 0; cyc < 40 && io < 3; cyc++) begin
        if (out_valid) begin
          check("b2b_sum", 32'(sum), 32'(pr[io].s));
          check("b2b_cout", 32'(cout), 32'(pr[io].co));
          check("b2b_ovf", 32'(ovf), 32'(pr[io].ov));
          io++;
        end
        acc = in_ready & in_valid;
        @(posedge clk); #1;
        if (acc) begin
          t_acc[ii] = cyc;
          ii++;
          if (ii < 3) begin
            a = pr[ii].a; b = pr[ii].b; cin = pr[ii].cin;
          end else in_valid = 0;
        end
      end
      in_valid = 0;
      check("b2b_results", io, 3);
      check("b2b_accepts", ii, 3);
      if (ii == 3) begin
        check("b2b_gap1", t_acc[1] - t_acc[0], 6);
        check("b2b_gap2", t_acc[2] - t_acc[1], 6);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
